// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with iterative MULTU/DIVU and valid/ready handshake
module alu_seq #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             z,
    output logic             n,
    output logic             v,
    output logic             busy
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_PASA = 4'b1010;
    localparam logic [3:0] OP_PASB = 4'b1011;
    localparam logic [3:0] OP_BP8  = 4'b1100;
    localparam logic [3:0] OP_MULU = 4'b1101;
    localparam logic [3:0] OP_DIVU = 4'b1110;
    localparam logic [3:0] OP_SLT  = 4'b1111;

    localparam logic [SHW:0] CNT_FULL = (SHW + 1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE  = (SHW + 1)'(1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nxt;
    logic [SHW:0]     count;
    logic             is_div;
    logic [WIDTH-1:0] acc_hi, acc_lo, opd;

    logic             accept;
    logic             multi;
    logic [WIDTH-1:0] sum, diff, alu_res;
    logic [SHW-1:0]   shamt;
    logic             flag_en, v_res;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] step_hi, step_lo;

    assign multi  = (op == OP_MULU) || (op == OP_DIVU);
    assign accept = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = multi ? BUSY : DONE;
            end
            BUSY: begin
                busy = 1'b1;
                if (count == CNT_ONE)
                    state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready)
                    state_nxt = in_valid ? (multi ? BUSY : DONE) : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sum     = a + b;
        diff    = a - b;
        shamt   = b[SHW-1:0];
        alu_res = '0;
        flag_en = 1'b0;
        v_res   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum;
                flag_en = 1'b1;
                v_res   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                flag_en = 1'b1;
                v_res   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = WIDTH'($signed(a) >>> shamt);
            OP_SLTU: begin
                alu_res = WIDTH'(a < b);
                flag_en = 1'b1;
            end
            OP_PASA: begin
                alu_res = a;
                flag_en = 1'b1;
            end
            OP_PASB: begin
                alu_res = b;
                flag_en = 1'b1;
            end
            OP_BP8:  alu_res = b + WIDTH'(8);
            OP_SLT: begin
                alu_res = WIDTH'($signed(a) < $signed(b));
                flag_en = 1'b1;
            end
            default: alu_res = '0;
        endcase
    end

    // Multiply: {acc_hi, acc_lo} is the running product with the multiplier
    // shifted out of acc_lo. Divide: acc_hi is the partial remainder and acc_lo
    // shifts dividend bits out while quotient bits shift in.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opd};
        div_ge    = div_shift >= {1'b0, opd};
        if (is_div) begin
            step_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            is_div    <= 1'b0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            opd       <= '0;
            result_lo <= '0;
            result_hi <= '0;
            z         <= 1'b0;
            n         <= 1'b0;
            v         <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                if (multi) begin
                    is_div <= (op == OP_DIVU);
                    count  <= CNT_FULL;
                    acc_hi <= '0;
                    acc_lo <= (op == OP_DIVU) ? a : b;
                    opd    <= (op == OP_DIVU) ? b : a;
                end else begin
                    result_lo <= alu_res;
                    result_hi <= '0;
                    z         <= flag_en && (alu_res == '0);
                    n         <= flag_en && alu_res[WIDTH-1];
                    v         <= v_res;
                end
            end else if (state == BUSY) begin
                acc_hi <= step_hi;
                acc_lo <= step_lo;
                count  <= count - 1'b1;
                if (count == CNT_ONE) begin
                    result_lo <= step_lo;
                    result_hi <= step_hi;
                    z         <= 1'b0;
                    n         <= 1'b0;
                    v         <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result_lo, result_hi;
    logic        z, n, v, busy;

    int n_cmp = 0;
    int n_err = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result_lo(result_lo), .result_hi(result_hi),
        .z(z), .n(n), .v(v), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if ({out_valid, busy, in_ready, z, n, v} !== 6'b001000) begin
            n_err++;
            $display("FAIL reset_ctl: got %b want 001000", {out_valid, busy, in_ready, z, n, v});
        end
        drive(4'b1110, 32'd100, 32'd7);
        cycle();
        in_valid = 1'b0;
        repeat (4) cycle();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_pre_busy: got %b want 1", busy);
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if ({out_valid, busy, in_ready, z, n, v} !== 6'b001000) begin
            n_err++;
            $display("FAIL reset_mid_ctl: got %b want 001000", {out_valid, busy, in_ready, z, n, v});
        end
        n_cmp++;
        if (result_lo !== 32'h0 || result_hi !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid_res: got %h_%h want 0_0", result_hi, result_lo);
        end
        repeat (40) cycle();
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_discard: got ov=%b busy=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops [4] = '{4'b0000, 4'b0001, 4'b1111, 4'b1001};
        logic [31:0] xa  [4] = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] xb  [4] = '{32'h1, 32'd5, 32'h1, 32'h1};
        logic [31:0] ex  [4] = '{32'h80000000, 32'h0, 32'h1, 32'h0};
        logic [2:0]  ef  [4] = '{3'b011, 3'b100, 3'b000, 3'b100};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(ops[i], xa[i], xb[i]);
            cycle();
            n_cmp++;
            if (out_valid !== 1'b1 || result_lo !== ex[i] || result_hi !== 32'h0) begin
                n_err++;
                $display("FAIL b2b_res[%0d]: got ov=%b %h_%h want ov=1 0_%h",
                         i, out_valid, result_hi, result_lo, ex[i]);
            end
            n_cmp++;
            if ({z, n, v} !== ef[i]) begin
                n_err++;
                $display("FAIL b2b_flags[%0d]: got znv=%b want %b", i, {z, n, v}, ef[i]);
            end
        end
        in_valid = 1'b0;
        cycle();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_drain: got ov=%b ir=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_shifts();
        logic [3:0]  ops [5] = '{4'b0110, 4'b1000, 4'b1100, 4'b0101, 4'b1010};
        logic [31:0] xa  [5] = '{32'h1, 32'h80000000, 32'h0, 32'h0, 32'h0};
        logic [31:0] xb  [5] = '{32'h21, 32'h4, 32'hFFFFFFFC, 32'h0, 32'h5};
        logic [31:0] ex  [5] = '{32'h2, 32'hF8000000, 32'h4, 32'hFFFFFFFF, 32'h0};
        logic [2:0]  ef  [5] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b100};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(ops[i], xa[i], xb[i]);
            cycle();
            n_cmp++;
            if (out_valid !== 1'b1 || result_lo !== ex[i] || {z, n, v} !== ef[i]) begin
                n_err++;
                $display("FAIL shift[%0d]: got ov=%b %h znv=%b want ov=1 %h znv=%b",
                         i, out_valid, result_lo, {z, n, v}, ex[i], ef[i]);
            end
        end
        in_valid = 1'b0;
        cycle();
    endtask

    task automatic test_multu();
        int bad = 0;
        out_ready = 1'b1;
        drive(4'b1101, 32'hFFFFFFFF, 32'hFFFFFFFF);
        cycle();
        in_valid = 1'b0;
        for (int e = 1; e <= 32; e++) begin
            if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
            a = $urandom;
            b = $urandom;
            op = 4'($urandom);
            cycle();
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL mul_busy: got %0d bad cycles want 0", bad);
        end
        n_cmp++;
        if (out_valid !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL mul_latency: got ov=%b busy=%b at edge 33 want 1 0", out_valid, busy);
        end
        n_cmp++;
        if (result_hi !== 32'hFFFFFFFE || result_lo !== 32'h00000001 || {z, n, v} !== 3'b000) begin
            n_err++;
            $display("FAIL mul_res: got %h_%h znv=%b want fffffffe_00000001 000",
                     result_hi, result_lo, {z, n, v});
        end
        cycle();
    endtask

    task automatic test_divu();
        logic [31:0] xa [2] = '{32'd100, 32'h1234};
        logic [31:0] xb [2] = '{32'd7, 32'h0};
        logic [31:0] el [2] = '{32'd14, 32'hFFFFFFFF};
        logic [31:0] eh [2] = '{32'd2, 32'h1234};
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(4'b1110, xa[i], xb[i]);
            cycle();
            in_valid = 1'b0;
            lat = 1;
            while (out_valid !== 1'b1 && lat < 40) begin
                cycle();
                lat++;
            end
            n_cmp++;
            if (lat != 33) begin
                n_err++;
                $display("FAIL div_latency[%0d]: got %0d want 33", i, lat);
            end
            n_cmp++;
            if (result_lo !== el[i] || result_hi !== eh[i]) begin
                n_err++;
                $display("FAIL div_res[%0d]: got %h_%h want %h_%h",
                         i, result_hi, result_lo, eh[i], el[i]);
            end
            cycle();
        end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        out_ready = 1'b0;
        drive(4'b0000, 32'd3, 32'd4);
        cycle();
        n_cmp++;
        if (out_valid !== 1'b1 || result_lo !== 32'd7) begin
            n_err++;
            $display("FAIL bp_first: got ov=%b %h want 1 00000007", out_valid, result_lo);
        end
        drive(4'b0100, 32'h0000F0F0, 32'h0000FFFF);
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result_lo !== 32'd7 ||
                result_hi !== 32'h0 || {z, n, v} !== 3'b000) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL bp_hold: got %0d unstable cycles want 0", bad);
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_ready: got %b want 1", in_ready);
        end
        cycle();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || result_lo !== 32'h00000F0F || result_hi !== 32'h0) begin
            n_err++;
            $display("FAIL bp_xor: got ov=%b %h_%h want 1 0_00000f0f", out_valid, result_hi, result_lo);
        end
        cycle();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_shifts();
        test_multu();
        test_divu();
        test_backpressure();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the combinational datapath ALU.
- Keeps the 4-bit opcode map and the Z/N flag rules, and adds:
  - a signed-overflow flag V;
  - iterative unsigned multiply (MULTU) and divide (DIVU) producing a double-width hi/lo result;
  - signed SLT.
- Sits between the EX-stage operand muxes and the HI/LO/result writeback, using a valid/ready handshake so that multi-cycle ops can stall the pipeline.

Parameters:
- WIDTH, 32, operand and result width; power of two, at least 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- op  in  4  opcode, encoding below.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer takes the result this cycle.
- result_lo  out  WIDTH  primary result; product low half or quotient.
- result_hi  out  WIDTH  product high half or remainder; 0 for all other ops.
- z  out  1  zero flag.
- n  out  1  negative flag.
- v  out  1  signed-overflow flag.
- busy  out  1  MULTU/DIVU iteration in progress.

Behaviour:
- Opcode map:
  - 0000 A+B; 0001 A-B; 0010 AND; 0011 OR; 0100 XOR; 0101 NOR.
  - 0110 A<<B[SHW-1:0]; 0111 A>>B[SHW-1:0] (logical); 1000 A>>>B[SHW-1:0] (arithmetic). Upper bits of B are ignored.
  - 1001 SLTU, unsigned A<B gives 1 else 0; 1010 pass A; 1011 pass B; 1100 B+8.
  - 1101 MULTU, {hi,lo} = A*B unsigned.
  - 1110 DIVU: lo = A/B, hi = A%B, unsigned.
  - 1111 SLT, signed A<B gives 1 else 0.
- All arithmetic is modulo 2^WIDTH except the MULTU full product.
- Flags:
  - z and n are computed from result_lo only for 0000, 0001, 1001, 1010, 1011, 1111; otherwise 0.
  - v is the signed overflow of 0000 and 0001 only; otherwise 0.
- FSM states IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid, capture op/a/b. Single-cycle ops (all except 1101/1110) load the result and flags and go to DONE. MULTU/DIVU load the operand registers, set count=WIDTH, and go to BUSY.
  - BUSY: in_ready=0, busy=1. Each cycle performs one shift-add (MULTU) or one restoring subtract step (DIVU), then count decrements. When count reaches 0, registers result_lo and result_hi, and z/n/v=0, and goes to DONE.
  - DONE: out_valid=1 and outputs are held stable until out_ready. in_ready = out_ready.
    - out_ready with in_valid: the new op is accepted in the same cycle and the next state follows the IDLE rules.
    - out_ready without in_valid: go to IDLE and drop out_valid.
- Latency from the accept edge:
  - Single-cycle ops: out_valid is high after 1 edge, so back-to-back throughput is 1 op per cycle when out_ready is held high.
  - MULTU/DIVU: out_valid is high after WIDTH+1 edges.
- Inputs are sampled only on the accept edge. Changes to a, b or op while in BUSY or DONE have no effect.
- in_valid while in BUSY, or while in DONE with out_ready=0, is not accepted. The requester must hold the request.
- DIVU with B=0 is not trapped:
  - lo = all ones, hi = A.
  - Latency is still WIDTH+1.
- Reset, including mid-BUSY or in DONE:
  - Next edge gives state IDLE and count 0.
  - out_valid=0, busy=0, result_lo=result_hi=0, z=n=v=0.
  - in_ready=1 the cycle after reset deasserts.
  - Any in-flight op is discarded.
- While out_valid=0, the result and flag outputs hold their last values and are not checked.

Test Plan:
- Reset: assert reset for 2 cycles during a DIVU in BUSY -> next cycle out_valid=0, busy=0, in_ready=1, result_lo=result_hi=0, z=n=v=0.
- Back-to-back single-cycle ops with out_ready=1:
  - ADD 0x7FFFFFFF+1 -> 0x80000000, n=1, v=1, z=0.
  - SUB 5-5 -> 0, z=1.
  - SLT 0xFFFFFFFF vs 1 -> 1.
  - SLTU 0xFFFFFFFF vs 1 -> 0, z=1.
  - Each result appears 1 cycle after its accept, with 1 result per cycle.
- Shifts:
  - SLL 0x1 by B=0x21 -> 0x2 (upper bits of B ignored).
  - SRA 0x80000000 by 4 -> 0xF8000000, z=n=0.
  - B+8 with B=0xFFFFFFFC -> 0x4.
- MULTU 0xFFFFFFFF*0xFFFFFFFF:
  - busy=1 for 32 cycles; out_valid at edge 33.
  - hi=0xFFFFFFFE, lo=0x00000001.
  - in_ready=0 throughout; a/b toggled during BUSY do not affect the result.
- DIVU: 100/7 -> lo=14, hi=2; 0x1234/0 -> lo=0xFFFFFFFF, hi=0x1234. Latency is 33 edges in both cases.
- Backpressure: hold out_ready=0 for 5 cycles after a DONE -> result and flags stable and in_ready=0. Then out_ready=1 with in_valid=1 (XOR 0xF0F0 ^ 0xFFFF) -> accepted that cycle, and the next out_valid shows 0x0F0F.
